asset_load_ctrl: RTL and testbench



---
 rtl/asset_load_pkg.sv | 22 ++
 rtl/load_byte_unpacker.sv | 74 +++++++
 rtl/asset_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_asset_load_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asset_load_pkg.sv
// +--------------------------------------------------------------------------+
// | asset_load_pkg: shared state encoding and HPS register map for the loader |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package asset_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [3:0] ADDR_CMD    = 4'd0;
  localparam logic [3:0] ADDR_RELOAD = 4'd1;
  localparam logic [3:0] ADDR_ABORT  = 4'd2;
  localparam logic [3:0] ADDR_CLRERR = 4'd3;

endpackage

`default_nettype wire

// File: rtl/load_byte_unpacker.sv
// +--------------------------------------------------------------------------+
// | load_byte_unpacker: pops source words and emits their bytes MSB first    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module load_byte_unpacker
  import asset_load_pkg::*;
#(
  parameter int SRC_W = 16
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             src_valid_i,
  input  logic [SRC_W-1:0] src_data_i,
  output logic             src_ready_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_o
);

  localparam int SRC_B = SRC_W / 8;
  localparam int CNT_W = $clog2(SRC_B + 1);

  logic [SRC_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             w_take;

  assign w_take      = ready_q && src_valid_i;
  assign src_ready_o = ready_q;

  // The first byte of a word leaves in its handshake cycle so a full word
  // stream sustains one byte per clock; only the remainder is buffered.
  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    byte_valid_o = 1'b0;
    byte_o       = word_q[SRC_W-1 -: 8];
    if (cnt_q != '0) begin
      if (en_i) begin
        byte_valid_o = 1'b1;
        word_d       = word_q << 8;
        cnt_d        = cnt_q - 1'b1;
      end
    end else if (w_take) begin
      byte_valid_o = 1'b1;
      byte_o       = src_data_i[SRC_W-1 -: 8];
      word_d       = src_data_i << 8;
      cnt_d        = CNT_W'(SRC_B - 1);
    end
    if (flush_i) begin
      word_d = '0;
      cnt_d  = '0;
    end
    ready_d = en_i && !flush_i && (cnt_d == '0);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/asset_load_ctrl.sv
// +--------------------------------------------------------------------------+
// | asset_load_ctrl: image-memory loader plus HPS render-command assembler   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module asset_load_ctrl
  import asset_load_pkg::*;
#(
  parameter  int PIXEL_BYTES = 3,
  parameter  int N_PIXELS    = 512,
  parameter  int SRC_W       = 16,
  parameter  int CMD_BYTES   = 6,
  localparam int ADDR_W      = $clog2(N_PIXELS)
) (
  input  logic                     clk50,
  input  logic                     reset,
  input  logic                     src_valid_i,
  input  logic [SRC_W-1:0]         src_data_i,
  output logic                     src_ready_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [PIXEL_BYTES*8-1:0] mem_din_o,
  input  logic                     hps_write_i,
  input  logic [3:0]               hps_address_i,
  input  logic [7:0]               hps_writedata_i,
  output logic                     cmd_valid_o,
  output logic [CMD_BYTES*8-1:0]   cmd_data_o,
  input  logic                     cmd_ready_i,
  output logic                     load_done_o,
  output logic                     err_overflow_o
);

  localparam int PIX_W = PIXEL_BYTES * 8;
  localparam int CMD_W = CMD_BYTES * 8;
  localparam int PC_W  = $clog2(PIXEL_BYTES + 1);
  localparam int IDX_W = $clog2(CMD_BYTES + 1);

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic              fin_q, fin_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_din_q, mem_din_d;
  logic [CMD_W-1:0]  asm_q, asm_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]  cmd_data_q, cmd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_unp_en, w_flush, w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_pix_byte, w_pix_done, w_last;
  logic [PIX_W-1:0]  w_pix_shift;
  logic [ADDR_W-1:0] w_cur_pix;
  logic              w_hps_run, w_reload, w_enter_load;
  logic              w_cmd_byte, w_cmd_done, w_accept, w_overflow;
  logic [CMD_W-1:0]  w_asm_shift;

  load_byte_unpacker #(
    .SRC_W (SRC_W)
  ) u_unpack (
    .clk50        (clk50),
    .reset        (reset),
    .en_i         (w_unp_en),
    .flush_i      (w_flush),
    .src_valid_i  (src_valid_i),
    .src_data_i   (src_data_i),
    .src_ready_o  (src_ready_o),
    .byte_valid_o (w_byte_valid),
    .byte_o       (w_byte)
  );

  assign w_unp_en    = (state_q == LOAD) && !fin_q;
  assign w_pix_byte  = w_unp_en && w_byte_valid;
  assign w_pix_shift = PIX_W'({pix_q, w_byte});
  assign w_pix_done  = w_pix_byte && (pcnt_q == PC_W'(PIXEL_BYTES - 1));
  // While a write is pulsing the address has not yet advanced to this pixel.
  assign w_cur_pix   = mem_we_q ? mem_addr_q + 1'b1 : mem_addr_q;
  assign w_last      = w_pix_done && (w_cur_pix == ADDR_W'(N_PIXELS - 1));

  assign w_hps_run    = hps_write_i && (state_q == RUN);
  assign w_reload     = w_hps_run && (hps_address_i == ADDR_RELOAD);
  assign w_enter_load = (state_q == IDLE) || w_reload;
  assign w_flush      = w_enter_load || w_last;

  assign w_cmd_byte  = w_hps_run && (hps_address_i == ADDR_CMD);
  assign w_asm_shift = CMD_W'({asm_q, hps_writedata_i});
  assign w_cmd_done  = w_cmd_byte && (idx_q == IDX_W'(CMD_BYTES - 1));
  assign w_accept    = cmd_valid_q && cmd_ready_i;
  assign w_overflow  = w_cmd_done && cmd_valid_q && !cmd_ready_i;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    pcnt_d      = pcnt_q;
    fin_d       = fin_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    asm_d       = asm_q;
    idx_d       = idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    err_d       = err_q;

    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    if (mem_we_q && fin_q) state_d = RUN;
      RUN:     if (w_reload) state_d = LOAD;
      default: state_d = IDLE;
    endcase

    if (w_enter_load) begin
      mem_addr_d = '0;
      pcnt_d     = '0;
      fin_d      = 1'b0;
    end else if (state_q == LOAD) begin
      if (mem_we_q && !fin_q) mem_addr_d = mem_addr_q + 1'b1;
      if (w_pix_byte) begin
        pix_d  = w_pix_shift;
        pcnt_d = pcnt_q + 1'b1;
      end
      if (w_pix_done) begin
        pcnt_d    = '0;
        mem_we_d  = 1'b1;
        mem_din_d = w_pix_shift;
      end
      if (w_last) fin_d = 1'b1;
    end
    done_d = (state_d == RUN);

    if (w_cmd_byte) begin
      asm_d = w_asm_shift;
      idx_d = w_cmd_done ? '0 : idx_q + 1'b1;
    end
    if (w_hps_run && (hps_address_i == ADDR_ABORT || hps_address_i == ADDR_RELOAD))
      idx_d = '0;

    if (w_accept) cmd_valid_d = 1'b0;
    if (w_cmd_done && !w_overflow) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = w_asm_shift;
    end

    if (hps_write_i && hps_address_i == ADDR_CLRERR) err_d = 1'b0;
    if (w_overflow) err_d = 1'b1;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      pcnt_q      <= '0;
      fin_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      asm_q       <= '0;
      idx_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      pcnt_q      <= pcnt_d;
      fin_q       <= fin_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_din_o      = mem_din_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_data_o     = cmd_data_q;
  assign load_done_o    = done_q;
  assign err_overflow_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_asset_load_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_asset_load_ctrl: randomized bench with a queue-based reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_asset_load_ctrl;

  localparam int PB = 3;
  localparam int NP = 4;
  localparam int SW = 16;
  localparam int CB = 6;
  localparam int AW = $clog2(NP);
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;

  logic            clk50 = 1'b0;
  logic            reset;
  logic            src_valid_i;
  logic [SW-1:0]   src_data_i;
  logic            src_ready_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [PB*8-1:0] mem_din_o;
  logic            hps_write_i;
  logic [3:0]      hps_address_i;
  logic [7:0]      hps_writedata_i;
  logic            cmd_valid_o;
  logic [CB*8-1:0] cmd_data_o;
  logic            cmd_ready_i;
  logic            load_done_o;
  logic            err_overflow_o;

  always #10 clk50 = ~clk50;

  asset_load_ctrl #(
    .PIXEL_BYTES (PB),
    .N_PIXELS    (NP),
    .SRC_W       (SW),
    .CMD_BYTES   (CB)
  ) dut (
    .clk50           (clk50),
    .reset           (reset),
    .src_valid_i     (src_valid_i),
    .src_data_i      (src_data_i),
    .src_ready_o     (src_ready_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_din_o       (mem_din_o),
    .hps_write_i     (hps_write_i),
    .hps_address_i   (hps_address_i),
    .hps_writedata_i (hps_writedata_i),
    .cmd_valid_o     (cmd_valid_o),
    .cmd_data_o      (cmd_data_o),
    .cmd_ready_i     (cmd_ready_i),
    .load_done_o     (load_done_o),
    .err_overflow_o  (err_overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: byte queues for the source path and command assembly.
  int         ph;
  logic [7:0] m_buf[$];
  logic [7:0] m_pix[$];
  logic [7:0] m_part[$];
  int         m_idx;
  bit         m_fin;
  bit         e_we, e_done, e_cv, e_err;
  int         e_addr;
  logic [PB*8-1:0] e_din;
  logic [CB*8-1:0] e_cmd;

  int          word_no;
  bit          seq_mode;
  logic [SW-1:0] cur_word;
  logic [PB*8-1:0] wr_din[$];
  int          wr_addr[$];

  task automatic model_reset();
    ph = PH_IDLE;
    m_buf.delete(); m_pix.delete(); m_part.delete();
    m_idx = 0; m_fin = 0;
    e_we = 0; e_done = 0; e_cv = 0; e_err = 0;
    e_addr = 0; e_din = '0; e_cmd = '0;
  endtask

  task automatic next_word();
    word_no++;
    if (seq_mode) cur_word = {8'(2*word_no + 1), 8'(2*word_no + 2)};
    else          cur_word = SW'($urandom);
  endtask

  task automatic model_edge();
    logic [7:0]      b;
    logic [CB*8-1:0] nc;
    bit got, was_we, acc, done_cmd, ovf;
    was_we = e_we;
    e_we   = 0;
    acc      = e_cv && cmd_ready_i;
    done_cmd = 0;
    ovf      = 0;
    nc       = '0;
    if (hps_write_i && ph == PH_RUN) begin
      if (hps_address_i == 4'd0) begin
        m_part.push_back(hps_writedata_i);
        if (m_part.size() == CB) begin
          foreach (m_part[i]) nc = {nc[CB*8-9:0], m_part[i]};
          m_part.delete();
          done_cmd = 1;
        end
      end else if (hps_address_i == 4'd1 || hps_address_i == 4'd2) begin
        m_part.delete();
      end
    end
    if (done_cmd) begin
      if (!e_cv || acc) begin e_cv = 1; e_cmd = nc; end
      else ovf = 1;
    end else if (acc) e_cv = 0;
    if (ovf) e_err = 1;
    else if (hps_write_i && hps_address_i == 4'd3) e_err = 0;

    case (ph)
      PH_IDLE: ph = PH_LOAD;
      PH_LOAD: begin
        if (was_we && m_fin) begin
          ph = PH_RUN;
          e_done = 1;
        end else if (!m_fin) begin
          got = 0;
          if (m_buf.size() > 0) begin
            b = m_buf.pop_front(); got = 1;
          end else if (src_ready_o && src_valid_i) begin
            for (int k = SW/8 - 1; k >= 0; k--) m_buf.push_back(cur_word[k*8 +: 8]);
            b = m_buf.pop_front(); got = 1;
          end
          if (got) begin
            m_pix.push_back(b);
            if (m_pix.size() == PB) begin
              e_we = 1; e_addr = m_idx; e_din = '0;
              foreach (m_pix[i]) e_din = {e_din[PB*8-9:0], m_pix[i]};
              m_pix.delete();
              m_idx++;
              if (m_idx == NP) begin m_fin = 1; m_buf.delete(); end
            end
          end
        end
      end
      default: begin
        if (hps_write_i && hps_address_i == 4'd1) begin
          ph = PH_LOAD;
          m_buf.delete(); m_pix.delete();
          m_idx = 0; m_fin = 0; e_done = 0;
        end
      end
    endcase
    if (!e_we) e_addr = (m_fin || ph == PH_RUN) ? NP - 1 : m_idx;
  endtask

  task automatic compare();
    bit ready_ok;
    ready_ok = (ph == PH_LOAD) && !m_fin && (m_buf.size() == 0);
    chk("mem_we", 64'(mem_we_o), 64'(e_we));
    chk("mem_addr", 64'(mem_addr_o), 64'(e_addr));
    chk("mem_din", 64'(mem_din_o), 64'(e_din));
    chk("load_done", 64'(load_done_o), 64'(e_done));
    chk("cmd_valid", 64'(cmd_valid_o), 64'(e_cv));
    chk("cmd_data", 64'(cmd_data_o), 64'(e_cmd));
    chk("err_overflow", 64'(err_overflow_o), 64'(e_err));
    chk("src_ready_legal", 64'(src_ready_o && !ready_ok), 64'(0));
    if (mem_we_o) begin
      wr_din.push_back(mem_din_o);
      wr_addr.push_back(int'(mem_addr_o));
    end
  endtask

  task automatic tick(input bit v, input bit hw, input logic [3:0] ha,
                      input logic [7:0] hd, input bit cr);
    src_valid_i     = v;
    src_data_i      = cur_word;
    hps_write_i     = hw;
    hps_address_i   = ha;
    hps_writedata_i = hd;
    cmd_ready_i     = cr;
    model_edge();
    if (src_ready_o && v) next_word();
    @(posedge clk50);
    @(negedge clk50);
    compare();
  endtask

  task automatic run_load(input string tag, input int budget, input bit rnd_valid);
    int c;
    c = 0;
    while (!load_done_o && c < budget) begin
      tick(rnd_valid ? ($urandom_range(3) != 0) : 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      c++;
    end
    chk(tag, 64'(load_done_o), 64'(1));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CB*8-1:0] first_cmd;
    logic [7:0]      bb;
    int              stalls, c;
    bit              hw;
    logic [3:0]      ha;
    int              r;

    reset = 1'b1;
    src_valid_i = 0; src_data_i = '0; hps_write_i = 0; hps_address_i = '0;
    hps_writedata_i = '0; cmd_ready_i = 0;
    seq_mode = 1; word_no = 0; cur_word = 16'h0102;
    model_reset();
    repeat (2) @(negedge clk50);
    compare();
    chk("rst_src_ready", 64'(src_ready_o), 64'(0));
    reset = 1'b0;

    // First load: sequential words with a 5-clock stall in the middle of pixel 1.
    stalls = 0;
    c = 0;
    while (!load_done_o && c < 60) begin
      if (word_no == 2 && stalls < 5) begin
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        stalls++;
      end else tick(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      c++;
    end
    chk("load1_done", 64'(load_done_o), 64'(1));
    chk("load1_nwr", 64'(wr_din.size()), 64'(4));
    if (wr_din.size() == 4) begin
      chk("pix0", 64'(wr_din[0]), 64'h010203);
      chk("pix1", 64'(wr_din[1]), 64'h040506);
      chk("pix2", 64'(wr_din[2]), 64'h070809);
      chk("pix3", 64'(wr_din[3]), 64'h0A0B0C);
      chk("addr3", 64'(wr_addr[3]), 64'(3));
    end
    repeat (3) tick(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("src_ready_after_load", 64'(src_ready_o), 64'(0));
    seq_mode = 0;

    // Command assembly and handshake.
    tick(1'b1, 1'b1, 4'd0, 8'hFF, 1'b0);
    for (int i = 1; i < 6; i++) tick(1'b1, 1'b1, 4'd0, 8'(i), 1'b0);
    tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("cmd_dir_valid", 64'(cmd_valid_o), 64'(1));
    chk("cmd_dir_data", 64'(cmd_data_o), 64'hFF0102030405);
    tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    chk("cmd_dir_accepted", 64'(cmd_valid_o), 64'(0));

    // Overflow: twelve bytes with the consumer stalled.
    first_cmd = '0;
    for (int i = 0; i < 12; i++) begin
      bb = 8'($urandom);
      if (i < 6) first_cmd = {first_cmd[CB*8-9:0], bb};
      tick(1'b0, 1'b1, 4'd0, bb, 1'b0);
    end
    chk("ovf_err", 64'(err_overflow_o), 64'(1));
    chk("ovf_held", 64'(cmd_data_o), 64'(first_cmd));
    tick(1'b0, 1'b1, 4'd3, 8'd0, 1'b0);
    chk("ovf_clear", 64'(err_overflow_o), 64'(0));
    tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

    // Abort a partial command, then send a full one.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'd0, 8'($urandom), 1'b0);
    tick(1'b0, 1'b1, 4'd2, 8'd0, 1'b0);
    first_cmd = '0;
    for (int i = 0; i < 6; i++) begin
      bb = 8'($urandom);
      first_cmd = {first_cmd[CB*8-9:0], bb};
      tick(1'b0, 1'b1, 4'd0, bb, 1'b0);
    end
    chk("abort_cmd", 64'(cmd_data_o), 64'(first_cmd));
    tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

    // Reload from RUN repeats the load from address 0.
    tick(1'b1, 1'b1, 4'd1, 8'd0, 1'b0);
    chk("reload_done_low", 64'(load_done_o), 64'(0));
    chk("reload_addr0", 64'(mem_addr_o), 64'(0));
    run_load("reload_done", 200, 1'b1);

    // Random traffic on both sides, including reloads and overflows.
    for (int i = 0; i < 800; i++) begin
      r  = $urandom_range(15);
      hw = ($urandom_range(2) == 0);
      if (r < 10)       ha = 4'd0;
      else if (r < 12)  ha = 4'd2;
      else if (r == 12) ha = 4'd3;
      else if (r == 13) ha = 4'd1;
      else              ha = 4'($urandom_range(15, 4));
      tick($urandom_range(3) != 0, hw, ha, 8'($urandom), $urandom_range(3) == 0);
    end

    // Reset in the middle of a load.
    run_load("pre_reset_done", 200, 1'b1);
    tick(1'b1, 1'b1, 4'd1, 8'd0, 1'b0);
    wr_din.delete(); wr_addr.delete();
    c = 0;
    while (wr_din.size() < 2 && c < 60) begin
      tick(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      c++;
    end
    chk("pre_reset_writes", 64'(wr_din.size()), 64'(2));
    reset = 1'b1;
    #1;
    chk("rst_mem_we", 64'(mem_we_o), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_mem_din", 64'(mem_din_o), 64'(0));
    chk("rst_cmd_valid", 64'(cmd_valid_o), 64'(0));
    chk("rst_cmd_data", 64'(cmd_data_o), 64'(0));
    chk("rst_load_done", 64'(load_done_o), 64'(0));
    chk("rst_err", 64'(err_overflow_o), 64'(0));
    chk("rst_ready", 64'(src_ready_o), 64'(0));
    model_reset();
    repeat (2) @(negedge clk50);
    compare();
    reset = 1'b0;
    wr_din.delete(); wr_addr.delete();
    run_load("post_reset_done", 200, 1'b1);
    chk("post_reset_nwr", 64'(wr_addr.size()), 64'(4));
    if (wr_addr.size() > 0) chk("post_reset_first_addr", 64'(wr_addr[0]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
